serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor. It is the next generation of the team's one-bit add/sub cell.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, with the carry held in a register between digits.
- Valid/ready handshake on both sides, plus carry, overflow and zero flags.
- Sits between operand registers and the ALU result mux wherever area matters more than single-cycle latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= WIDTH.
- Derived: N = WIDTH/DIGIT digit steps per operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair and opcode valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  1  0 = a+b, 1 = a-b.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference.
- cout  out  1  final carry out; for subtract, 1 = no borrow (a >= b unsigned).
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low.
- Reset, asserted asynchronously:
  - state = IDLE; digit counter, carry register, operand and result registers = 0.
  - out_valid, cout, overflow, zero = 0; result = 0.
  - in_ready = (state == IDLE) && rst_n, so it is 0 while reset is held.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready at an edge, capture a, b ^ {WIDTH{opcode}}, carry = opcode, count = 0; go to RUN.
  - RUN: in_ready = 0. Each edge adds digit[count] of A, digit[count] of B' and carry, then writes the DIGIT sum bits into result digit[count]. Count increments; when count == N-1, go to DONE.
  - DONE: out_valid = 1, in_ready = 0. result, cout, overflow and zero stay stable until out_ready. On out_valid && out_ready, go to IDLE.
- Latency: if an operation is accepted at edge k, out_valid rises after edge k+N. With N = 1, DONE follows the acceptance edge by one cycle.
- No overlap: the next operation can be accepted no earlier than the edge after the result handshake, giving a throughput of one operation per N+2 cycles.
- Arithmetic:
  - Sum is modulo 2^WIDTH (wrap-around).
  - cout = carry out of bit WIDTH-1.
  - overflow = (A[msb] == B'[msb]) && (result[msb] != A[msb]).
  - Flags are registered on the final RUN edge.
- in_valid while not IDLE is ignored; the operands are not captured.
- out_ready while not in DONE has no effect.
- Reset mid-operation (RUN or DONE) aborts the transaction immediately: out_valid drops to 0 asynchronously and the operation is not replayed.
- Edge cases: a - a always gives result 0, zero = 1, cout = 1, overflow = 0. Adding the most-negative value to itself gives result 0 with cout = 1 and overflow = 1.

Optional Feature:
- Macro: SERIAL_ADD_SUB_SAT_EN.
- Defined: on overflow, result is replaced by the signed saturation value. This is 0x7F..F when A[msb] == 0, otherwise 0x80..0. cout and overflow still report the raw operation; zero is computed on the saturated value.
- Undefined: result always wraps; no saturation logic is present.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - state encoding for IDLE, RUN and DONE (2-bit);
  - the saturation constant generator by width.
- One sub-module, digit_add_sub: a combinational DIGIT-bit ripple slice.
  - Inputs: a_d, b_d, cin.
  - Outputs: sum_d, cout_d, and msb_cin for overflow.
  - Instantiated once; the top level holds the FSM, counter and shift/indexing.

Test Plan (WIDTH = 32, DIGIT = 8 unless stated):
1. Add 0x0000_0005 + 0x0000_0003, out_ready = 1 -> result 0x0000_0008, cout 0, overflow 0, zero 0; out_valid rises exactly 4 edges after acceptance.
2. Subtract 0x1234_5678 - 0x1234_5678 -> result 0, zero 1, cout 1, overflow 0.
3. Add 0x7FFF_FFFF + 0x0000_0001 -> result 0x8000_0000, overflow 1, cout 0. With SERIAL_ADD_SUB_SAT_EN -> result 0x7FFF_FFFF, overflow 1.
4. Subtract 0x0000_0000 - 0x0000_0001 -> result 0xFFFF_FFFF, cout 0 (borrow), overflow 0. Repeat with DIGIT = 32 and DIGIT = 1; latency is 1 and 32 edges respectively.
5. Backpressure: hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid -> result and flags stay constant, in_ready stays 0, no capture. Releasing out_ready completes the handshake, and in_ready = 1 on the next cycle.
6. Assert rst_n = 0 on the second RUN cycle -> out_valid and all flags are 0 immediately. After release, a new operation 0x0000_00FF + 0x0000_0001 gives 0x0000_0100 with correct latency.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub_pkg
// Purpose  : Shared definitions for the digit-serial adder/subtractor:
//            opcode constants, FSM state encoding and the signed saturation
//            constant generator.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest operand the saturation generator supports.
  localparam int SAT_MAX_W = 256;

  // Signed saturation value for a given width: 0x7F..F for a positive
  // overflow (neg = 0), 0x80..0 for a negative overflow (neg = 1).
  // Callers keep the low 'width' bits.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic neg);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width - 1)
        v[i] = ~neg;
      else if (i == width - 1)
        v[i] = neg;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_sub_digit.sv
`default_nettype none
// ============================================================================
// Module   : digit_add_sub
// Purpose  : Combinational DIGIT-bit ripple add slice used by serial_add_sub.
// Ports    : a_d, b_d (DIGIT) - operand digits (b_d already inverted for sub)
//            cin            - carry into the digit
//            sum_d (DIGIT)  - digit sum
//            cout_d         - carry out of the digit MSB
//            msb_cin        - carry into the digit MSB (for overflow)
// Revision : 1.0 - initial release
// ============================================================================
module digit_add_sub #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] sum_d,
  output logic             cout_d,
  output logic             msb_cin
);

  logic [DIGIT:0] w_full;

  assign w_full = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, cin};
  assign sum_d  = w_full[DIGIT-1:0];
  assign cout_d = w_full[DIGIT];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
  assign msb_cin = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ sum_d[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub
// Purpose  : Multi-cycle two's-complement adder/subtractor. Processes a
//            WIDTH-bit operand pair DIGIT bits per clock, LSB digit first,
//            with the inter-digit carry held in a register.
// Ports    : clk, rst_n (async, active-low)
//            in_valid / in_ready   - operation handshake (a, b, opcode)
//            out_valid / out_ready - result handshake
//            result, cout, overflow, zero - result and flags
// Config   : SERIAL_ADD_SUB_SAT_EN - when defined, signed overflow replaces
//            the result with the saturation value.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic [DIGIT-1:0]   w_sum_d;
  logic               w_cout_d;
  logic               w_msb_cin;
  logic [WIDTH-1:0]   w_res_next;
  logic [WIDTH-1:0]   w_final;
  logic               w_last;
  logic               w_ovf;

  // Operands are shifted right after every digit, so the current digit is
  // always in the low DIGIT bits.
  digit_add_sub #(.DIGIT(DIGIT)) u_digit (
    .a_d     (r_a[DIGIT-1:0]),
    .b_d     (r_b[DIGIT-1:0]),
    .cin     (r_carry),
    .sum_d   (w_sum_d),
    .cout_d  (w_cout_d),
    .msb_cin (w_msb_cin)
  );

  // Result digits enter at the top and shift down; after N digits the first
  // digit has reached bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single_digit
      assign w_res_next = w_sum_d;
    end else begin : g_multi_digit
      assign w_res_next = {w_sum_d, r_result[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (r_cnt == CNT_W'(N - 1));
  // Only meaningful on the final digit: carry-in vs carry-out of the MSB.
  assign w_ovf  = w_cout_d ^ w_msb_cin;

`ifdef SERIAL_ADD_SUB_SAT_EN
  // A's MSB is in r_a[DIGIT-1] during the final digit.
  assign w_final = w_ovf ? WIDTH'(sat_value(WIDTH, r_a[DIGIT-1])) : w_res_next;
`else
  assign w_final = w_res_next;
`endif

  assign in_ready  = (r_state == ST_IDLE) && rst_n;
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtract as a + ~b + 1.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{opcode == OP_SUB}};
            r_carry <= (opcode == OP_SUB);
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_cout_d;
          if (w_last) begin
            r_result <= w_final;
            r_cout   <= w_cout_d;
            r_ovf    <= w_ovf;
            r_zero   <= (w_final == '0);
            r_state  <= ST_DONE;
          end else begin
            r_result <= w_res_next;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sub
// Purpose  : Directed self-checking bench for serial_add_sub (WIDTH = 32,
//            DIGIT = 8 main instance, plus DIGIT = 32 and DIGIT = 1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         opcode = 1'b0;

  // main instance, DIGIT = 8
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, cout, overflow, zero;
  logic [W-1:0] result;

  // DIGIT = 32 instance
  logic         s_in_valid = 1'b0;
  logic         s_out_ready = 1'b1;
  logic         s_in_ready, s_out_valid, s_cout, s_overflow, s_zero;
  logic [W-1:0] s_result;

  // DIGIT = 1 instance
  logic         t_in_valid = 1'b0;
  logic         t_out_ready = 1'b1;
  logic         t_in_ready, t_out_valid, t_cout, t_overflow, t_zero;
  logic [W-1:0] t_result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(W), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow), .zero(zero)
  );

  serial_add_sub #(.WIDTH(W), .DIGIT(32)) dut_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .cout(s_cout), .overflow(s_overflow), .zero(s_zero)
  );

  serial_add_sub #(.WIDTH(W), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .result(t_result), .cout(t_cout), .overflow(t_overflow), .zero(t_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full operation on the main instance; called #1 after a rising edge.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic iop, input logic [31:0] er,
                        input logic ec, input logic eo, input logic ez);
    int lat;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ia; b = ib; opcode = iop;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk({tag, ".result"},  result, er);
    chk({tag, ".cout"},     32'(cout), 32'(ec));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".zero"},     32'(zero), 32'(ez));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"},  32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",  32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result",    result, 32'd0);
    chk("rst.flags",     {29'd0, cout, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready_rel", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Basic add
    run_op("add5p3", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold out_ready low in DONE while pulsing in_valid
    a = 32'h10; b = 32'h20; opcode = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 32'(i * 7 + 100);
      b = 32'hFFFF_0000;
      chk("bp.result",    result, 32'h30);
      chk("bp.in_ready",  32'(in_ready), 32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.flags",     {29'd0, cout, overflow, zero}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.out_valid_drop", 32'(out_valid), 32'd0);
    chk("bp.in_ready_back",  32'(in_ready), 32'd1);
    chk("bp.no_capture",     result, 32'h30);

    // Borrow case on all three digit widths
    run_op("sub0m1", 32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    a = 32'h0; b = 32'h1; opcode = 1'b1;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d32.latency", 32'(lat), 32'd1);
    chk("d32.result",  s_result, 32'hFFFF_FFFF);
    chk("d32.flags",   {29'd0, s_cout, s_overflow, s_zero}, 32'd0);
    @(posedge clk); #1;
    chk("d32.in_ready_back", 32'(s_in_ready), 32'd1);

    t_in_valid = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    lat = 0;
    while (!t_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d1.latency", 32'(lat), 32'd32);
    chk("d1.result",  t_result, 32'hFFFF_FFFF);
    chk("d1.flags",   {29'd0, t_cout, t_overflow, t_zero}, 32'd0);
    @(posedge clk); #1;
    chk("d1.in_ready_back", 32'(t_in_ready), 32'd1);

    // a - a
    run_op("subaa", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    // Most-negative + most-negative
    run_op("addmn", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Reset on the second RUN cycle (flags are non-zero from the previous op)
    a = 32'h1234_5678; b = 32'h1234_5678; opcode = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.flags",     {29'd0, cout, overflow, zero}, 32'd0);
    chk("abort.result",    result, 32'd0);
    chk("abort.in_ready",  32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort.no_replay", 32'(out_valid), 32'd0);
    run_op("postrst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

    // Signed overflow, wrap or saturate
`ifdef SERIAL_ADD_SUB_SAT_EN
    run_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
    run_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
